// File: rtl/cpu_traffic_gen.sv
// CPU-side request generator for cache/memory bring-up: LFSR-random or sequential
// write/readback requests paced on ack. Define CPU_TG_TIMEOUT_EN to add the ack watchdog.
module cpu_traffic_gen #(
  parameter int                ADDR_W    = 16,
  parameter int                DATA_W    = 32,
  parameter int                BE_W      = DATA_W / 8,
  parameter logic [ADDR_W-1:0] ADDR_MASK = 16'hFFFF,
  parameter logic [31:0]       SEED      = 32'hACE12345,
  parameter int                GAP       = 4
`ifdef CPU_TG_TIMEOUT_EN
  , parameter int              TIMEOUT_CYC = 1024
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [15:0]       req_count,
  input  logic              ack,
  output logic [ADDR_W-1:0] addr,
  output logic              wr,
  output logic              rd,
  output logic [DATA_W-1:0] wdata,
  output logic [BE_W-1:0]   bval,
  output logic              busy,
  output logic              done,
  output logic [15:0]       issued,
  output logic              timeout_err
);

  localparam logic [31:0] LFSR_POLY = 32'h80200003;
  localparam int          GAP_W     = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_GAP, ST_REQ, ST_FIN} state_t;

  state_t              state;
  logic [31:0]         lfsr;
  logic [31:0]         lfsr_next;
  logic [ADDR_W-1:0]   seq_addr;
  logic [ADDR_W-1:0]   seq_cur;
  logic [ADDR_W-1:0]   seq_next;
  logic [ADDR_W:0]     seq_sum;
  logic [2*ADDR_W-1:0] seq_pat;
  logic                seq_rd;
  logic [GAP_W-1:0]    gap_cnt;
  logic                mode_q;
  logic [15:0]         count_q;
  logic [DATA_W-1:0]   rnd_wdata;
  logic [DATA_W-1:0]   seq_wdata;
  logic [BE_W-1:0]     rnd_bval;

`ifdef CPU_TG_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] wd_cnt;
  logic            timeout_q;
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  // Candidate next request for both modes; the FSM picks one when leaving GAP.
  always_comb begin
    lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? LFSR_POLY : 32'h0);
    seq_cur   = seq_addr & ADDR_MASK;
    seq_pat   = {seq_cur, ~seq_cur};
    seq_sum   = {1'b0, seq_addr} + (ADDR_W+1)'(BE_W);
    seq_next  = (seq_sum > {1'b0, ADDR_MASK}) ? '0 : seq_sum[ADDR_W-1:0];
    for (int i = 0; i < DATA_W; i++) begin
      rnd_wdata[i] = lfsr[i % 32];
      seq_wdata[i] = seq_pat[i % (2*ADDR_W)];
    end
    rnd_bval = BE_W'(lfsr[0]) << (int'(lfsr[31:24]) % BE_W);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      lfsr     <= SEED;
      seq_addr <= '0;
      seq_rd   <= 1'b0;
      gap_cnt  <= '0;
      mode_q   <= 1'b0;
      count_q  <= '0;
      addr     <= '0;
      wr       <= 1'b0;
      rd       <= 1'b0;
      wdata    <= '0;
      bval     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      issued   <= '0;
`ifdef CPU_TG_TIMEOUT_EN
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q  <= mode;
            count_q <= req_count;
            issued  <= '0;
            busy    <= 1'b1;
            seq_rd  <= 1'b0;
            gap_cnt <= '0;
`ifdef CPU_TG_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            if (req_count == 16'd0) begin
              state <= ST_FIN;
              done  <= 1'b1;
            end else begin
              state <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_W'(GAP - 1)) begin
            gap_cnt <= '0;
            state   <= ST_REQ;
`ifdef CPU_TG_TIMEOUT_EN
            wd_cnt  <= '0;
`endif
            if (!mode_q) begin
              addr  <= lfsr[ADDR_W:1] & ADDR_MASK;
              wr    <= lfsr[0];
              rd    <= ~lfsr[0];
              wdata <= rnd_wdata;
              bval  <= rnd_bval;
              lfsr  <= lfsr_next;
            end else begin
              // Write then read back the same address; advance only after the read.
              addr   <= seq_cur;
              wr     <= ~seq_rd;
              rd     <= seq_rd;
              wdata  <= seq_wdata;
              bval   <= seq_rd ? '0 : '1;
              seq_rd <= ~seq_rd;
              if (seq_rd) seq_addr <= seq_next;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        ST_REQ: begin
          if (ack) begin
            wr     <= 1'b0;
            rd     <= 1'b0;
            bval   <= '0;
            issued <= issued + 16'd1;
            if (issued + 16'd1 == count_q) begin
              state <= ST_FIN;
              done  <= 1'b1;
            end else begin
              state <= ST_GAP;
            end
          end
`ifdef CPU_TG_TIMEOUT_EN
          else if (wd_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            wr        <= 1'b0;
            rd        <= 1'b0;
            bval      <= '0;
            timeout_q <= 1'b1;
            state     <= ST_FIN;
            done      <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        ST_FIN: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_traffic_gen.sv
// Randomized self-checking bench for cpu_traffic_gen against a request-level reference model.
// Define CPU_TG_TIMEOUT_EN to also exercise the ack watchdog.
module tb_cpu_traffic_gen;

  localparam int          ADDR_W    = 16;
  localparam int          DATA_W    = 32;
  localparam int          BE_W      = 4;
  localparam int          GAP       = 4;
  localparam logic [15:0] ADDR_MASK = 16'h001F;
  localparam logic [31:0] SEED      = 32'hACE12345;
  localparam logic [31:0] POLY      = 32'h80200003;
`ifdef CPU_TG_TIMEOUT_EN
  localparam int          TIMEOUT_CYC = 16;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              mode = 1'b0;
  logic [15:0]       req_count = '0;
  logic              ack = 1'b0;
  logic [ADDR_W-1:0] addr;
  logic              wr;
  logic              rd;
  logic [DATA_W-1:0] wdata;
  logic [BE_W-1:0]   bval;
  logic              busy;
  logic              done;
  logic [15:0]       issued;
  logic              timeout_err;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_lfsr = SEED;
  int          m_seq_addr = 0;
  bit          m_seq_rd = 1'b0;

  cpu_traffic_gen #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ADDR_MASK(ADDR_MASK), .SEED(SEED), .GAP(GAP)
`ifdef CPU_TG_TIMEOUT_EN
    , .TIMEOUT_CYC(TIMEOUT_CYC)
`endif
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .req_count(req_count),
    .ack(ack), .addr(addr), .wr(wr), .rd(rd), .wdata(wdata), .bval(bval),
    .busy(busy), .done(done), .issued(issued), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("[TB] FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "[TB] global time limit exceeded");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Next request from the model: random mode walks the Galois LFSR, sequential mode
  // walks write/read pairs with address stride BE_W, wrapping past the mask.
  task automatic predictNext(input bit m, output logic [15:0] e_addr, output bit e_wr,
                             output logic [31:0] e_wdata, output logic [3:0] e_bval);
    if (!m) begin
      e_wr    = m_lfsr[0];
      e_addr  = 16'((m_lfsr >> 1) & {16'h0, ADDR_MASK});
      e_wdata = m_lfsr;
      e_bval  = e_wr ? 4'(1 << ((m_lfsr >> 24) % BE_W)) : 4'h0;
      m_lfsr  = (m_lfsr >> 1) ^ (m_lfsr[0] ? POLY : 32'h0);
    end else begin
      e_addr  = 16'(m_seq_addr);
      e_wr    = !m_seq_rd;
      e_wdata = {e_addr, ~e_addr};
      e_bval  = m_seq_rd ? 4'h0 : 4'hF;
      if (m_seq_rd) begin
        m_seq_addr += BE_W;
        if (m_seq_addr > int'(ADDR_MASK)) m_seq_addr = 0;
      end
      m_seq_rd = !m_seq_rd;
    end
  endtask

  task automatic waitRequest(output int cycles);
    cycles = 1;
    while (!(wr || rd) && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  // hold: 0 = short random ack delay, 1 = 20-cycle hold plus start while busy, 2 = never ack
  task automatic applyStimulus(input bit m, input int count, input int hold);
    int          cyc;
    int          delay;
    logic [15:0] ea;
    bit          ew;
    logic [31:0] ed;
    logic [3:0]  eb;
    logic [15:0] a0;
    logic [31:0] d0;
    start = 1'b1;
    mode = m;
    req_count = 16'(count);
    @(negedge clk);
    start = 1'b0;
    mode = 1'($urandom);
    req_count = 16'($urandom);
    m_seq_rd = 1'b0;
    checkOutput("busy_after_start", busy, 1);
    checkOutput("issued_cleared", issued, 0);
    checkOutput("timeout_cleared", timeout_err, 0);
    if (count == 0) begin
      checkOutput("done_zero_count", done, 1);
      checkOutput("no_req_zero_count", wr | rd, 0);
      @(negedge clk);
      checkOutput("done_one_cycle", done, 0);
      checkOutput("idle_zero_count", busy, 0);
      checkOutput("no_req_after_zero", wr | rd, 0);
      return;
    end
    for (int k = 0; k < count; k++) begin
      waitRequest(cyc);
      checkOutput("req_spacing", cyc, GAP + 1);
      predictNext(m, ea, ew, ed, eb);
      checkOutput("wr", wr, ew);
      checkOutput("rd", rd, !ew);
      checkOutput("addr", addr, ea);
      checkOutput("bval", bval, eb);
      if (ew) checkOutput("wdata", wdata, ed);
      checkOutput("done_mid_run", done, 0);
`ifdef CPU_TG_TIMEOUT_EN
      if (hold == 2) begin
        for (int i = 1; i < TIMEOUT_CYC; i++) begin
          @(negedge clk);
          checkOutput("to_wr_held", wr, 1);
        end
        @(negedge clk);
        checkOutput("to_dropped", wr | rd, 0);
        checkOutput("to_done", done, 1);
        checkOutput("to_err", timeout_err, 1);
        checkOutput("to_issued", issued, 0);
        @(negedge clk);
        checkOutput("to_idle", busy, 0);
        checkOutput("to_err_sticky", timeout_err, 1);
        return;
      end
`endif
      delay = (hold == 1 && k == 0) ? 20 : $urandom_range(0, 3);
      a0 = addr;
      d0 = wdata;
      for (int i = 0; i < delay; i++) begin
        if (hold == 1 && i == 5) begin
          start = 1'b1;
          mode = !m;
          req_count = 16'd3;
        end
        @(negedge clk);
        start = 1'b0;
        checkOutput("hold_wr", wr, ew);
        checkOutput("hold_rd", rd, !ew);
        checkOutput("hold_addr", addr, a0);
        checkOutput("hold_wdata", wdata, d0);
      end
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      checkOutput("req_dropped_after_ack", wr | rd, 0);
      checkOutput("bval_idle", bval, 0);
      checkOutput("issued_count", issued, k + 1);
      checkOutput("done_at_end", done, (k == count - 1) ? 1 : 0);
    end
    @(negedge clk);
    checkOutput("done_pulse_width", done, 0);
    checkOutput("busy_end", busy, 0);
    checkOutput("issued_final", issued, count);
    checkOutput("timeout_err_final", timeout_err, 0);
  endtask

  task automatic resetMidRun();
    int cyc;
    start = 1'b1;
    mode = 1'b0;
    req_count = 16'd6;
    @(negedge clk);
    start = 1'b0;
    waitRequest(cyc);
    checkOutput("rst_req_present", wr | rd, 1);
    reset = 1'b0;
    #1;
    checkOutput("rst_wr", wr, 0);
    checkOutput("rst_rd", rd, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_addr", addr, 0);
    checkOutput("rst_bval", bval, 0);
    checkOutput("rst_issued", issued, 0);
    @(negedge clk);
    reset = 1'b1;
    m_lfsr = SEED;
    m_seq_addr = 0;
    @(negedge clk);
    checkOutput("rst_no_done", done, 0);
    checkOutput("rst_idle", busy, 0);
  endtask

  initial begin
    @(negedge clk);
    checkOutput("init_wr", wr, 0);
    checkOutput("init_rd", rd, 0);
    checkOutput("init_addr", addr, 0);
    checkOutput("init_wdata", wdata, 0);
    checkOutput("init_busy", busy, 0);
    checkOutput("init_done", done, 0);
    checkOutput("init_issued", issued, 0);
    reset = 1'b1;

    ack = 1'b1;
    repeat (2) @(negedge clk);
    ack = 1'b0;
    checkOutput("ack_in_idle_busy", busy, 0);
    checkOutput("ack_in_idle_req", wr | rd, 0);

    applyStimulus(1'b0, 8, 0);
    applyStimulus(1'b1, 4, 0);
    applyStimulus(1'b1, 20, 0);
    applyStimulus(1'b0, 3, 1);
    applyStimulus(1'b1, 0, 0);

    for (int r = 0; r < 10; r++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 9), 0);
    end

`ifdef CPU_TG_TIMEOUT_EN
    applyStimulus(1'b1, 2, 2);
    applyStimulus(1'b1, 2, 0);
`endif

    resetMidRun();
    applyStimulus(1'b0, 4, 0);
    applyStimulus(1'b1, 5, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
